dir_input_conditioner: RTL

- Front-end stage directly upstream of ALUDataPath. Conditions the four raw push-button inputs (up, down, left, right) into clean, single direction events.
- Per button: synchronises, debounces and edge-detects the input.
- Arbitrates simultaneous presses by fixed priority. Generates auto-repeat while a button is held.
- Delivers each event as a 2-bit direction code over a valid/ready handshake to the datapath.

---
 rtl/dir_input_conditioner_if.sv | 10 +
 rtl/dir_input_conditioner.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dir_input_conditioner_if.sv
// Direction event handshake between the input conditioner and the datapath.
`timescale 1ns/1ps
interface dir_input_conditioner_if;
  logic       dir_valid;
  logic       dir_ready;
  logic [1:0] dir_code;

  modport master (output dir_valid, output dir_code, input dir_ready);
  modport slave  (input dir_valid, input dir_code, output dir_ready);
endinterface

// File: rtl/dir_input_conditioner.sv
// Push-button front end: per-button sync + debounce, fixed-priority arbiter
// with auto-repeat, single-entry valid/ready event buffer with sticky overrun.
`timescale 1ns/1ps
module dir_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10,
  parameter int CNT_W           = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     up,
  input  logic                     down,
  input  logic                     left,
  input  logic                     right,
  dir_input_conditioner_if.master  dir_if,
  output logic                     dir_held,
  output logic [3:0]               btn_state,
  output logic                     overrun
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  // Bit order {up,down,left,right}; direction code = 3 - bit index.
  logic [3:0] raw;
  assign raw = {up, down, left, right};

  logic [SYNC_STAGES-1:0] sync_q [4];
  logic [SYNC_STAGES-1:0] sync_d [4];
  logic [3:0]             sync_out;

  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [3:0]       stable_q, stable_d;

  logic [0:0]       state_q, state_d;
  logic [1:0]       lock_q, lock_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;

  logic       ev_fire;
  logic [1:0] ev_code;
  logic [1:0] arb_code;
  logic [1:0] lock_idx;
  logic       released;

  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       ovr_q, ovr_d;

  // Synchroniser chains: shift the raw level in, oldest stage is the output.
  always_comb begin
    for (int unsigned b = 0; b < 4; b++) begin
      sync_d[b]   = {sync_q[b][SYNC_STAGES-2:0], raw[b]};
      sync_out[b] = sync_q[b][SYNC_STAGES-1];
    end
  end

  // Debounce: count cycles of disagreement, accept the new level once the count is reached.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned b = 0; b < 4; b++) begin
      db_cnt_d[b] = db_cnt_q[b];
      if (sync_out[b] == stable_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES)) begin
        stable_d[b] = sync_out[b];
        db_cnt_d[b] = '0;
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + 1'b1;
      end
    end
  end

  // Fixed-priority pick among debounced levels: up > down > left > right.
  always_comb begin
    if (stable_q[3])      arb_code = 2'd0;
    else if (stable_q[2]) arb_code = 2'd1;
    else if (stable_q[1]) arb_code = 2'd2;
    else                  arb_code = 2'd3;
  end

  // Release is taken from the next stable level so that IDLE re-arbitrates
  // in the cycle right after btn_state drops; it also beats repeat expiry.
  assign lock_idx = 2'd3 - lock_q;
  assign released = ~stable_d[lock_idx];

  // Arbiter FSM: lock a direction, fire the first event, then auto-repeat until release.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rpt_d   = rpt_q;
    ev_fire = 1'b0;
    ev_code = lock_q;
    case (state_q)
      IDLE: begin
        if (|stable_q) begin
          lock_d  = arb_code;
          ev_fire = 1'b1;
          ev_code = arb_code;
          rpt_d   = CNT_W'(REPEAT_DELAY);
          state_d = HELD;
        end
      end
      default: begin
        if (released) begin
          state_d = IDLE;
          rpt_d   = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rpt_q <= CNT_W'(1)) begin
            ev_fire = 1'b1;
            rpt_d   = CNT_W'(REPEAT_PERIOD);
          end else begin
            rpt_d = rpt_q - 1'b1;
          end
        end
      end
    endcase
  end

  // Single-entry event buffer: load when empty or draining, otherwise drop and flag overrun.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = ovr_q;
    if (ev_fire) begin
      if (!valid_q || dir_if.dir_ready) begin
        valid_d = 1'b1;
        code_d  = ev_code;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && dir_if.dir_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        sync_q[b]   <= '0;
        db_cnt_q[b] <= '0;
      end
      stable_q <= '0;
      state_q  <= IDLE;
      lock_q   <= '0;
      rpt_q    <= '0;
      valid_q  <= 1'b0;
      code_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        sync_q[b]   <= sync_d[b];
        db_cnt_q[b] <= db_cnt_d[b];
      end
      stable_q <= stable_d;
      state_q  <= state_d;
      lock_q   <= lock_d;
      rpt_q    <= rpt_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dir_if.dir_valid = valid_q;
  assign dir_if.dir_code  = code_q;
  assign dir_held         = (state_q == HELD);
  assign btn_state        = stable_q;
  assign overrun          = ovr_q;

endmodule
